chip_test_sequencer: RTL

Vector-driven test sequencer that runs a selected chip's stored test vectors against the socketed device under test. It is started by the chip-checker control FSM's `Start_Check` and answers with `Check_Done`. For each vector it:
- fetches the vector from a synchronous vector ROM,
- drives the chip input pins and waits a settle period,
- samples the synchronized chip outputs and compares them under a mask.

It accumulates pass/fail results, which the control FSM loads into the result/display registers.

---
 rtl/chip_test_sequencer_if.sv | 30 +++
 rtl/chip_test_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/chip_test_sequencer_if.sv
// Bundle between the chip-checker control/ROM/socket side and the test sequencer.
// master = sequencer side, slave = control FSM, vector ROM and socket side.
interface chip_test_sequencer_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int VEC_W = 4,
  parameter int SEL_W = 3
);
  logic                     Start_Check;
  logic [SEL_W-1:0]         Chip_Sel;
  logic [SEL_W+VEC_W-1:0]   Vec_Addr;
  logic [N_IN+2*N_OUT:0]    Vec_Data;
  logic [N_IN-1:0]          Chip_In;
  logic [N_OUT-1:0]         Chip_Out;
  logic                     Check_Done;
  logic                     Pass;
  logic [VEC_W:0]           Fail_Count;
  logic [VEC_W-1:0]         First_Fail;
  logic [VEC_W:0]           Vec_Count;

  modport master (
    input  Start_Check, Chip_Sel, Vec_Data, Chip_Out,
    output Vec_Addr, Chip_In, Check_Done, Pass, Fail_Count, First_Fail, Vec_Count
  );

  modport slave (
    output Start_Check, Chip_Sel, Vec_Data, Chip_Out,
    input  Vec_Addr, Chip_In, Check_Done, Pass, Fail_Count, First_Fail, Vec_Count
  );
endinterface

// File: rtl/chip_test_sequencer.sv
// Runs the selected chip's stored vectors against the socketed DUT and accumulates pass/fail results.
// SETTLE+3 cycles per vector; start edges are honoured only in IDLE or DONE, otherwise ignored.
module chip_test_sequencer #(
  parameter int N_IN   = 8,
  parameter int N_OUT  = 4,
  parameter int VEC_W  = 4,
  parameter int SEL_W  = 3,
  parameter int SETTLE = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  chip_test_sequencer_if.master  bus
);
  localparam int                CNT_W       = 4;
  localparam int                DAT_W       = N_IN + 2*N_OUT + 1;
  localparam logic [VEC_W:0]    CNT_ONE     = (VEC_W+1)'(1);
  localparam logic [VEC_W-1:0]  IDX_ONE     = VEC_W'(1);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LOAD, ST_SETTLE, ST_SAMPLE, ST_DONE
  } state_t;

  state_t            state, state_next;
  logic              start_q;
  logic              start_ok;
  logic              mismatch;
  logic              final_vec;
  logic [N_OUT-1:0]  sync_a;
  logic [N_OUT-1:0]  out_s;
  logic [N_OUT-1:0]  exp_bits;
  logic [N_OUT-1:0]  mask_bits;
  logic              last_bit;
  logic [SEL_W-1:0]  sel;
  logic [VEC_W-1:0]  idx;
  logic [VEC_W-1:0]  first_fail;
  logic [CNT_W-1:0]  settle_cnt;
  logic [N_IN-1:0]   chip_in;
  logic [VEC_W:0]    vec_count;
  logic [VEC_W:0]    fail_count;
  logic              check_done;
  logic              pass;

  always_comb begin
    start_ok   = bus.Start_Check & ~start_q & ((state == ST_IDLE) | (state == ST_DONE));
    mismatch   = |((out_s ^ exp_bits) & mask_bits);
    final_vec  = last_bit | (idx == '1);
    state_next = state;
    case (state)
      ST_IDLE:   if (start_ok) state_next = ST_FETCH;
      ST_FETCH:  state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == '0) state_next = ST_SAMPLE;
      ST_SAMPLE: state_next = final_vec ? ST_DONE : ST_FETCH;
      ST_DONE:   if (start_ok) state_next = ST_FETCH;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Chip_Out is asynchronous to Clk; only out_s is ever compared.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      start_q <= 1'b0;
      sync_a  <= '0;
      out_s   <= '0;
    end else begin
      start_q <= bus.Start_Check;
      sync_a  <= bus.Chip_Out;
      out_s   <= sync_a;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sel        <= '0;
      idx        <= '0;
      exp_bits   <= '0;
      mask_bits  <= '0;
      last_bit   <= 1'b0;
      settle_cnt <= '0;
      chip_in    <= '0;
      vec_count  <= '0;
      fail_count <= '0;
      first_fail <= '0;
      check_done <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (start_ok) begin
        sel        <= bus.Chip_Sel;
        idx        <= '0;
        chip_in    <= '0;
        vec_count  <= '0;
        fail_count <= '0;
        first_fail <= '0;
        check_done <= 1'b0;
        pass       <= 1'b0;
      end

      if (state == ST_LOAD) begin
        chip_in    <= bus.Vec_Data[DAT_W-1 -: N_IN];
        exp_bits   <= bus.Vec_Data[2*N_OUT -: N_OUT];
        mask_bits  <= bus.Vec_Data[N_OUT -: N_OUT];
        last_bit   <= bus.Vec_Data[0];
        settle_cnt <= SETTLE_LOAD;
      end

      if ((state == ST_SETTLE) && (settle_cnt != '0))
        settle_cnt <= settle_cnt - CNT_ONE[CNT_W-1:0];

      // Results become final in the same edge that enters DONE, so Check_Done never leads them.
      if (state == ST_SAMPLE) begin
        vec_count <= vec_count + CNT_ONE;
        if (mismatch) begin
          fail_count <= fail_count + CNT_ONE;
          if (fail_count == '0)
            first_fail <= idx;
        end
        if (final_vec) begin
          chip_in    <= '0;
          check_done <= 1'b1;
          pass       <= (fail_count == '0) & ~mismatch;
        end else begin
          idx <= idx + IDX_ONE;
        end
      end
    end
  end

  assign bus.Vec_Addr   = {sel, idx};
  assign bus.Chip_In    = chip_in;
  assign bus.Check_Done = check_done;
  assign bus.Pass       = pass;
  assign bus.Fail_Count = fail_count;
  assign bus.First_Fail = first_fail;
  assign bus.Vec_Count  = vec_count;

endmodule
